mem_arbiter: RTL and testbench

- Sits directly downstream of the core's external memory interface, between the core and a single-ported system memory bus.
- Merges instruction-cache refills and data-cache reads onto one request/ack bus.
- Posts data stores into a small in-order write buffer so stores never stall the core unless the buffer fills.
- Returns one-cycle valid pulses that the caches use as fill strobes.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/wbuf_fifo.sv | 81 ++++++++
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory arbiter: the arbiter state encoding and
// the posted-write entry layout at the default bus widths.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int STATE_W = 2;
    localparam int DEF_AW  = 32;
    localparam int DEF_DW  = 32;

    localparam logic [STATE_W-1:0] IDLE_ENC  = 2'd0;
    localparam logic [STATE_W-1:0] IREAD_ENC = 2'd1;
    localparam logic [STATE_W-1:0] DREAD_ENC = 2'd2;
    localparam logic [STATE_W-1:0] WRITE_ENC = 2'd3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = IDLE_ENC,
        ST_IREAD = IREAD_ENC,
        ST_DREAD = DREAD_ENC,
        ST_WRITE = WRITE_ENC
    } arb_state_e;

    // One posted store as it travels to the bus.
    typedef struct packed {
        logic [DEF_AW-1:0] addr;
        logic [DEF_DW-1:0] data;
    } bus_entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// -----------------------------------------------------------------------------
// wbuf_fifo
// In-order synchronous FIFO used as the posted-write buffer.
//   clk, rst   : clock, asynchronous active-high reset
//   push_i     : enqueue wdata_i (ignored while full)
//   pop_i      : dequeue head (ignored while empty)
//   wdata_i    : entry to enqueue
//   rdata_o    : current head entry
//   count_o    : number of stored entries
//   full_o     : count == DEPTH (registered)
//   empty_o    : count == 0     (registered)
// -----------------------------------------------------------------------------
module wbuf_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_push = push_i && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop_i  && (count_q != '0);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // NOTE: storage is not reset; count and pointers define which entries
    // are valid, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Merges instruction refills, data reads and posted stores onto a single
// request/ack memory bus.
//   Core side : i_iread_en/i_iaddr -> o_inst/o_iread_vd (refill)
//               i_dread_en/i_daddr -> o_drdata/o_dread_vd (data read)
//               i_dwrite_en/i_daddr/i_dwdata (posted store)
//               o_wfull, o_wempty, o_overflow (write buffer status)
//   Bus side  : o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata, i_mem_ack/i_mem_rdata
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WBUF_DEPTH = 4,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_iread_en,
    input  logic [AW-1:0] i_iaddr,
    output logic [DW-1:0] o_inst,
    output logic          o_iread_vd,
    input  logic          i_dread_en,
    input  logic          i_dwrite_en,
    input  logic [AW-1:0] i_daddr,
    input  logic [DW-1:0] i_dwdata,
    output logic [DW-1:0] o_drdata,
    output logic          o_dread_vd,
    output logic          o_wfull,
    output logic          o_wempty,
    output logic          o_overflow,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic          i_mem_ack,
    input  logic [DW-1:0] i_mem_rdata
);

    localparam int EW = AW + DW;

    arb_state_e state_q, state_d;

    logic          mem_req_q,   mem_req_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] inst_q,      inst_d;
    logic [DW-1:0] drdata_q,    drdata_d;
    logic          iread_vd_q,  iread_vd_d;
    logic          dread_vd_q,  dread_vd_d;
    logic          overflow_q;

    logic                        wbuf_pop;
    logic [EW-1:0]               wbuf_head;
    logic [$clog2(WBUF_DEPTH):0] wbuf_count;
    logic                        wbuf_full, wbuf_empty, wbuf_nonempty;
    logic                        iread_pend, dread_pend;

    wbuf_fifo #(
        .DEPTH (WBUF_DEPTH),
        .W     (EW)
    ) u_wbuf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (i_dwrite_en),
        .pop_i   (wbuf_pop),
        .wdata_i ({i_daddr, i_dwdata}),
        .rdata_o (wbuf_head),
        .count_o (wbuf_count),
        .full_o  (wbuf_full),
        .empty_o (wbuf_empty)
    );

    assign wbuf_nonempty = (wbuf_count != '0);

    // A requester that just got its valid pulse still holds its enable for
    // one edge while the cache turns hit; mask it so it is not re-issued.
    assign iread_pend = i_iread_en && !iread_vd_q;
    assign dread_pend = i_dread_en && !dread_vd_q;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        inst_d      = inst_q;
        drdata_d    = drdata_q;
        iread_vd_d  = 1'b0;
        dread_vd_d  = 1'b0;
        wbuf_pop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Stores drain completely before any data read so a read
                // never overtakes an older store to the same address.
                if (wbuf_nonempty && (dread_pend || wbuf_full)) state_d = ST_WRITE;
                else if (dread_pend && !wbuf_nonempty)         state_d = ST_DREAD;
                else if (iread_pend)                           state_d = ST_IREAD;
                else if (wbuf_nonempty)                        state_d = ST_WRITE;
            end
            ST_IREAD: if (i_mem_ack) begin
                state_d    = ST_IDLE;
                inst_d     = i_mem_rdata;
                iread_vd_d = 1'b1;
            end
            ST_DREAD: if (i_mem_ack) begin
                state_d    = ST_IDLE;
                drdata_d   = i_mem_rdata;
                dread_vd_d = 1'b1;
            end
            ST_WRITE: if (i_mem_ack) begin
                state_d  = ST_IDLE;
                wbuf_pop = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus outputs are launched once on leaving IDLE and then held.
        if (state_q == ST_IDLE && state_d != ST_IDLE) begin
            mem_req_d = 1'b1;
            mem_we_d  = (state_d == ST_WRITE);
            case (state_d)
                ST_WRITE: begin
                    mem_addr_d  = wbuf_head[EW-1:DW];
                    mem_wdata_d = wbuf_head[DW-1:0];
                end
                ST_DREAD: begin
                    mem_addr_d  = i_daddr;
                    mem_wdata_d = '0;
                end
                default: begin
                    mem_addr_d  = i_iaddr;
                    mem_wdata_d = '0;
                end
            endcase
        end else if (state_q != ST_IDLE && state_d == ST_IDLE) begin
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            inst_q      <= '0;
            drdata_q    <= '0;
            iread_vd_q  <= 1'b0;
            dread_vd_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            inst_q      <= inst_d;
            drdata_q    <= drdata_d;
            iread_vd_q  <= iread_vd_d;
            dread_vd_q  <= dread_vd_d;
            // A store that finds the buffer full is lost; flag it until reset.
            if (i_dwrite_en && wbuf_full) overflow_q <= 1'b1;
        end
    end

    assign o_inst      = inst_q;
    assign o_iread_vd  = iread_vd_q;
    assign o_drdata    = drdata_q;
    assign o_dread_vd  = dread_vd_q;
    assign o_wfull     = wbuf_full;
    assign o_wempty    = wbuf_empty;
    assign o_overflow  = overflow_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed self-checking bench for mem_arbiter. Inputs change 1 time unit
// after the rising edge; outputs are checked at the same point.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_iread_en;
    logic [31:0] i_iaddr;
    logic [31:0] o_inst;
    logic        o_iread_vd;
    logic        i_dread_en;
    logic        i_dwrite_en;
    logic [31:0] i_daddr;
    logic [31:0] i_dwdata;
    logic [31:0] o_drdata;
    logic        o_dread_vd;
    logic        o_wfull;
    logic        o_wempty;
    logic        o_overflow;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.WBUF_DEPTH(4), .AW(32), .DW(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_iread_en  (i_iread_en),
        .i_iaddr     (i_iaddr),
        .o_inst      (o_inst),
        .o_iread_vd  (o_iread_vd),
        .i_dread_en  (i_dread_en),
        .i_dwrite_en (i_dwrite_en),
        .i_daddr     (i_daddr),
        .i_dwdata    (i_dwdata),
        .o_drdata    (o_drdata),
        .o_dread_vd  (o_dread_vd),
        .o_wfull     (o_wfull),
        .o_wempty    (o_wempty),
        .o_overflow  (o_overflow),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a one-cycle ack; returns in the cycle after the ack edge.
    task automatic ack_with(input logic [31:0] d);
        i_mem_ack   = 1'b1;
        i_mem_rdata = d;
        tick();
        i_mem_ack   = 1'b0;
        i_mem_rdata = '0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        i_dwrite_en = 1'b1;
        i_daddr     = a;
        i_dwdata    = d;
    endtask

    bus_entry_t exp_w [3];
    bus_entry_t exp_f [4];

    initial begin
        rst = 1'b1;
        i_iread_en = 0; i_iaddr = '0; i_dread_en = 0; i_dwrite_en = 0;
        i_daddr = '0; i_dwdata = '0; i_mem_ack = 0; i_mem_rdata = '0;
        exp_w[0] = '{addr: 32'h200, data: 32'h1};
        exp_w[1] = '{addr: 32'h204, data: 32'h2};
        exp_w[2] = '{addr: 32'h208, data: 32'h3};
        for (int i = 0; i < 4; i++) exp_f[i] = '{addr: 32'h1000 + 32'(i * 4), data: 32'hA0 + 32'(i)};

        // ---------------- reset state ----------------
        tick(); tick();
        check("rst_req",      64'(o_mem_req),   64'd0);
        check("rst_we",       64'(o_mem_we),    64'd0);
        check("rst_addr",     64'(o_mem_addr),  64'd0);
        check("rst_wempty",   64'(o_wempty),    64'd1);
        check("rst_wfull",    64'(o_wfull),     64'd0);
        check("rst_overflow", 64'(o_overflow),  64'd0);
        check("rst_ivd",      64'(o_iread_vd),  64'd0);
        check("rst_inst",     64'(o_inst),      64'd0);
        rst = 1'b0;
        tick();

        // ---------------- single refill ----------------
        i_iread_en = 1; i_iaddr = 32'h100;
        tick();
        check("t1_req",  64'(o_mem_req),  64'd1);
        check("t1_addr", 64'(o_mem_addr), 64'h100);
        check("t1_we",   64'(o_mem_we),   64'd0);
        tick(); tick();
        check("t1_req_held", 64'(o_mem_req), 64'd1);
        ack_with(32'h13);
        check("t1_ivd",      64'(o_iread_vd), 64'd1);
        check("t1_inst",     64'(o_inst),     64'h13);
        check("t1_req_drop", 64'(o_mem_req),  64'd0);
        tick();  // enable still high across the pulse edge
        i_iread_en = 0;
        check("t1_ivd_one",  64'(o_iread_vd), 64'd0);
        check("t1_no_reiss", 64'(o_mem_req),  64'd0);
        tick();
        check("t1_no_reiss2", 64'(o_mem_req), 64'd0);

        // ---------------- posted stores behind a refill ----------------
        i_iread_en = 1; i_iaddr = 32'h140;
        store(exp_w[0].addr, exp_w[0].data);
        tick();
        check("t2_ireq",  64'(o_mem_req),  64'd1);
        check("t2_iaddr", 64'(o_mem_addr), 64'h140);
        check("t2_iwe",   64'(o_mem_we),   64'd0);
        store(exp_w[1].addr, exp_w[1].data);
        tick();
        store(exp_w[2].addr, exp_w[2].data);
        tick();
        i_dwrite_en = 0;
        check("t2_wempty0", 64'(o_wempty), 64'd0);
        ack_with(32'h0000AAAA);
        i_iread_en = 0;
        check("t2_ivd",  64'(o_iread_vd), 64'd1);
        check("t2_inst", 64'(o_inst),     64'h0000AAAA);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t2_w%0d_req", i),  64'(o_mem_req),   64'd1);
            check($sformatf("t2_w%0d_we", i),   64'(o_mem_we),    64'd1);
            check($sformatf("t2_w%0d_addr", i), 64'(o_mem_addr),  64'(exp_w[i].addr));
            check($sformatf("t2_w%0d_data", i), 64'(o_mem_wdata), 64'(exp_w[i].data));
            ack_with('0);
        end
        check("t2_wempty1", 64'(o_wempty),   64'd1);
        check("t2_no_ivd",  64'(o_iread_vd), 64'd0);
        tick();
        check("t2_idle", 64'(o_mem_req), 64'd0);

        // ---------------- full and overflow ----------------
        store(exp_f[0].addr, exp_f[0].data); tick();
        store(exp_f[1].addr, exp_f[1].data); tick();
        store(exp_f[2].addr, exp_f[2].data); tick();
        check("t3_nfull3", 64'(o_wfull), 64'd0);
        store(exp_f[3].addr, exp_f[3].data); tick();
        check("t3_full4",  64'(o_wfull),    64'd1);
        check("t3_novf4",  64'(o_overflow), 64'd0);
        store(32'h2000, 32'hDEAD); tick();
        i_dwrite_en = 0;
        check("t3_ovf",    64'(o_overflow), 64'd1);
        check("t3_full5",  64'(o_wfull),    64'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_w%0d_req", i),  64'(o_mem_req),   64'd1);
            check($sformatf("t3_w%0d_we", i),   64'(o_mem_we),    64'd1);
            check($sformatf("t3_w%0d_addr", i), 64'(o_mem_addr),  64'(exp_f[i].addr));
            check($sformatf("t3_w%0d_data", i), 64'(o_mem_wdata), 64'(exp_f[i].data));
            ack_with('0);
            if (i < 3) tick();
        end
        check("t3_wempty", 64'(o_wempty), 64'd1);
        tick();
        check("t3_no_5th", 64'(o_mem_req),  64'd0);
        check("t3_sticky", 64'(o_overflow), 64'd1);
        tick();
        check("t3_no_5th_b", 64'(o_mem_req), 64'd0);
        rst = 1'b1;
        tick();
        check("t3_ovf_clr", 64'(o_overflow), 64'd0);
        rst = 1'b0;
        tick();

        // ---------------- read after write ----------------
        store(32'h300, 32'hAB);
        tick();
        i_dwrite_en = 0;
        i_dread_en = 1; i_daddr = 32'h300;
        tick();
        check("t4_wreq",  64'(o_mem_req),   64'd1);
        check("t4_wwe",   64'(o_mem_we),    64'd1);
        check("t4_waddr", 64'(o_mem_addr),  64'h300);
        check("t4_wdata", 64'(o_mem_wdata), 64'hAB);
        ack_with('0);
        check("t4_no_dvd", 64'(o_dread_vd), 64'd0);
        tick();
        check("t4_rreq",  64'(o_mem_req),  64'd1);
        check("t4_rwe",   64'(o_mem_we),   64'd0);
        check("t4_raddr", 64'(o_mem_addr), 64'h300);
        ack_with(32'hDEADBEEF);
        i_dread_en = 0;
        check("t4_dvd",    64'(o_dread_vd), 64'd1);
        check("t4_drdata", 64'(o_drdata),   64'hDEADBEEF);
        tick();
        check("t4_dvd_one", 64'(o_dread_vd), 64'd0);
        check("t4_idle",    64'(o_mem_req),  64'd0);

        // ---------------- simultaneous requests ----------------
        i_dread_en = 1; i_daddr = 32'h400;
        i_iread_en = 1; i_iaddr = 32'h500;
        tick();
        check("t5_dreq",  64'(o_mem_req),  64'd1);
        check("t5_daddr", 64'(o_mem_addr), 64'h400);
        check("t5_dwe",   64'(o_mem_we),   64'd0);
        ack_with(32'h44);
        i_dread_en = 0;
        check("t5_dvd",    64'(o_dread_vd), 64'd1);
        check("t5_drdata", 64'(o_drdata),   64'h44);
        check("t5_no_ivd", 64'(o_iread_vd), 64'd0);
        tick();
        check("t5_ireq",   64'(o_mem_req),  64'd1);
        check("t5_iaddr",  64'(o_mem_addr), 64'h500);
        check("t5_dvd_one", 64'(o_dread_vd), 64'd0);
        ack_with(32'h55);
        i_iread_en = 0;
        check("t5_ivd",  64'(o_iread_vd), 64'd1);
        check("t5_inst", 64'(o_inst),     64'h55);
        tick();
        check("t5_ivd_one", 64'(o_iread_vd), 64'd0);
        check("t5_idle",    64'(o_mem_req),  64'd0);

        // ---------------- reset mid-transaction ----------------
        i_dread_en = 1; i_daddr = 32'h600;
        tick();
        check("t6_dreq", 64'(o_mem_req), 64'd1);
        store(32'h610, 32'h1); tick();
        store(32'h614, 32'h2); tick();
        i_dwrite_en = 0;
        check("t6_wempty0", 64'(o_wempty),  64'd0);
        check("t6_req_hold", 64'(o_mem_req), 64'd1);
        #2;
        rst = 1'b1;
        i_mem_ack = 1'b1; i_mem_rdata = 32'h66;
        #1;
        check("t6_async_req",    64'(o_mem_req),  64'd0);
        check("t6_async_addr",   64'(o_mem_addr), 64'd0);
        check("t6_async_wempty", 64'(o_wempty),   64'd1);
        check("t6_async_dvd",    64'(o_dread_vd), 64'd0);
        tick();
        i_mem_ack = 1'b0; i_mem_rdata = '0; i_dread_en = 0;
        tick();
        rst = 1'b0;
        tick();
        check("t6_post_dvd",  64'(o_dread_vd), 64'd0);
        check("t6_post_req",  64'(o_mem_req),  64'd0);
        check("t6_post_drd",  64'(o_drdata),   64'd0);
        i_iread_en = 1; i_iaddr = 32'h700;
        tick();
        check("t6_ireq",  64'(o_mem_req),  64'd1);
        check("t6_iaddr", 64'(o_mem_addr), 64'h700);
        ack_with(32'h77);
        i_iread_en = 0;
        check("t6_ivd",  64'(o_iread_vd), 64'd1);
        check("t6_inst", 64'(o_inst),     64'h77);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
